lfsr_prbs_sync_check: RTL and testbench

- Receive-side PRBS checker. Sits directly downstream of lfsr_prbs_gen, or after a link/loopback carrying its output.
- Self-synchronises to the incoming pattern and declares lock after a run of clean words.
- Once locked, free-runs a local LFSR and counts bit errors in a saturating counter for BER measurement.

---
 rtl/lfsr_prbs_pkg.sv | 15 +
 rtl/lfsr_prbs_step.sv | 44 ++++
 rtl/lfsr_prbs_sync_check.sv | 155 +++++++++++++++
 tb/tb_lfsr_prbs_sync_check.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_prbs_pkg.sv
// Shared types and constants for the PRBS checker slice.
// State encoding, PRBS31 defaults and the popcount width helper.
package lfsr_prbs_pkg;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int              PRBS31_WIDTH = 31;
  localparam logic [30:0]     PRBS31_POLY  = 31'h10000001;

  function automatic int pc_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/lfsr_prbs_step.sv
// Combinational N-bit Fibonacci LFSR stepper, one word per call.
// SELF_SYNC=1 shifts in the fed bits; 0 shifts in its own prediction.
module lfsr_prbs_step
  import lfsr_prbs_pkg::*;
#(
  parameter int              W         = PRBS31_WIDTH,
  parameter logic [W-1:0]    POLY      = PRBS31_POLY,
  parameter int              DW        = 8,
  parameter bit              REVERSE   = 1'b0,
  parameter bit              SELF_SYNC = 1'b1
) (
  input  logic [W-1:0]  state,
  input  logic [DW-1:0] feed,
  output logic [W-1:0]  next_state,
  output logic [DW-1:0] pred
);

  // state[0] is the newest bit; POLY bit k taps the bit W-k steps back
  function automatic logic [W-1:0] tap_mask();
    logic [W-1:0] m;
    for (int j = 0; j < W; j++) m[j] = POLY[W-1-j];
    return m;
  endfunction

  localparam logic [W-1:0] TAPS = tap_mask();

  always_comb begin
    logic [W-1:0] st;
    logic         b;
    int           idx;
    st   = state;
    pred = '0;
    b    = 1'b0;
    idx  = 0;
    for (int t = 0; t < DW; t++) begin
      idx       = REVERSE ? t : DW - 1 - t;
      b         = ^(st & TAPS);
      pred[idx] = b;
      st        = {st[W-2:0], SELF_SYNC ? feed[idx] : b};
    end
    next_state = st;
  end

endmodule

// File: rtl/lfsr_prbs_sync_check.sv
// Self-synchronising PRBS checker with lock FSM and saturating BER counter.
// Optional word counter output: LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN.
module lfsr_prbs_sync_check
  import lfsr_prbs_pkg::*;
#(
  parameter int                   LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter                       LFSR_CONFIG  = "FIBONACCI",
  parameter bit                   REVERSE      = 1'b0,
  parameter bit                   INVERT       = 1'b1,
  parameter int                   DATA_WIDTH   = 8,
  parameter int                   LOCK_COUNT   = 8,
  parameter int                   UNLOCK_COUNT = 4,
  parameter int                   COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   err_clear,
  output logic [DATA_WIDTH-1:0]  err_out,
  output logic                   err_out_valid,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] err_count,
`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
  output logic [COUNT_WIDTH-1:0] word_count,
`endif
  output logic                   err_count_sat
);

  if (LFSR_CONFIG != "FIBONACCI") begin : g_bad_cfg
    $error("lfsr_prbs_sync_check: only FIBONACCI is supported");
  end

  localparam int           PW      = pc_width(DATA_WIDTH);
  localparam logic [7:0]   LOCK_N  = 8'(LOCK_COUNT);
  localparam logic [7:0]   UNLK_N  = 8'(UNLOCK_COUNT);

  logic [0:0]            state;
  logic [7:0]            run;
  logic [LFSR_WIDTH-1:0] hist;
  logic [LFSR_WIDTH-1:0] hist_nx;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_nx;
  logic [DATA_WIDTH-1:0] rx;
  logic [DATA_WIDTH-1:0] hist_pred;
  logic [DATA_WIDTH-1:0] free_pred;
  logic [DATA_WIDTH-1:0] mask;
  logic [PW-1:0]         pc;
  logic                  clean;
  logic                  acc;
  logic [COUNT_WIDTH:0]  sum;
  logic [COUNT_WIDTH-1:0] cnt_nx;

  assign rx = INVERT ? ~data_in : data_in;

  lfsr_prbs_step #(
    .W(LFSR_WIDTH), .POLY(LFSR_POLY), .DW(DATA_WIDTH),
    .REVERSE(REVERSE), .SELF_SYNC(1'b1)
  ) u_hist (
    .state(hist), .feed(rx),
    .next_state(hist_nx), .pred(hist_pred)
  );

  lfsr_prbs_step #(
    .W(LFSR_WIDTH), .POLY(LFSR_POLY), .DW(DATA_WIDTH),
    .REVERSE(REVERSE), .SELF_SYNC(1'b0)
  ) u_free (
    .state(lfsr), .feed('0),
    .next_state(lfsr_nx), .pred(free_pred)
  );

  assign mask  = rx ^ ((state == LOCKED) ? free_pred : hist_pred);
  assign clean = (mask == '0);
  assign acc   = data_in_valid && (state == LOCKED);

  always_comb begin
    pc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pc = pc + PW'(mask[i]);
  end

  // Clear and accumulate in one cycle leaves just this word's bits
  always_comb begin
    sum = (err_clear ? '0 : {1'b0, err_count})
        + (COUNT_WIDTH + 1)'(pc);
    if (acc)
      cnt_nx = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    else
      cnt_nx = err_clear ? '0 : err_count;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      run           <= '0;
      hist          <= '1;
      lfsr          <= '1;
      err_out       <= '0;
      err_out_valid <= 1'b0;
      err_count     <= '0;
      err_count_sat <= 1'b0;
    end else begin
      err_out_valid <= data_in_valid;
      err_count     <= cnt_nx;
      err_count_sat <= &cnt_nx;
      if (data_in_valid) begin
        err_out <= mask;
        hist    <= hist_nx;
        if (state == LOCKED) lfsr <= lfsr_nx;
        unique case (state)
          HUNT: begin
            if (!clean) begin
              run <= '0;
            end else if (run + 8'd1 == LOCK_N) begin
              state <= LOCKED;
              lfsr  <= hist_nx;
              run   <= '0;
            end else begin
              run <= run + 8'd1;
            end
          end
          LOCKED: begin
            if (clean) begin
              run <= '0;
            end else if (run + 8'd1 == UNLK_N) begin
              state <= HUNT;
              run   <= '0;
            end else begin
              run <= run + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
    end else if (acc) begin
      if (err_clear)
        word_count <= COUNT_WIDTH'(1);
      else if (word_count != '1)
        word_count <= word_count + COUNT_WIDTH'(1);
    end else if (err_clear) begin
      word_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prbs_sync_check.sv
// Bench for lfsr_prbs_sync_check: bit-sequence reference model,
// two instances (32-bit and 4-bit counters) fed the same stimulus.
module tb_lfsr_prbs_sync_check;

  localparam int W = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        err_clear = 1'b0;

  logic [7:0]  a_eo, b_eo;
  logic        a_eov, b_eov, a_lk, b_lk, a_sat, b_sat;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;
`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
  logic [31:0] a_wc;
  logic [3:0]  b_wc;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [30:0] poly_v = 31'h10000001;

  bit     gq[$];
  bit     rq[$];
  bit     lq[$];
  bit     m_locked;
  int     m_run;
  longint m_cnt;
  logic [7:0] m_out;
  bit     m_valid;

  always #5 clk = ~clk;

  lfsr_prbs_sync_check #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .err_clear(err_clear),
    .err_out(a_eo), .err_out_valid(a_eov),
    .locked(a_lk), .err_count(a_cnt),
`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
    .word_count(a_wc),
`endif
    .err_count_sat(a_sat)
  );

  lfsr_prbs_sync_check #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .err_clear(err_clear),
    .err_out(b_eo), .err_out_valid(b_eov),
    .locked(b_lk), .err_count(b_cnt),
`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
    .word_count(b_wc),
`endif
    .err_count_sat(b_sat)
  );

  // PRBS rule: next bit = XOR of bits (W-k) steps back for each poly bit k
  function automatic bit rec(input bit q[$]);
    bit p;
    p = 1'b0;
    for (int k = 0; k < W; k++)
      if (poly_v[k]) p ^= q[q.size() - (W - k)];
    return p;
  endfunction

  function automatic void gen_reset();
    gq.delete();
    for (int i = 0; i < W; i++) gq.push_back(1'b1);
  endfunction

  // Upstream generator: MSB-first, inverted on the wire
  function automatic logic [7:0] gen_word();
    logic [7:0] w;
    bit b;
    for (int t = 0; t < 8; t++) begin
      b = rec(gq);
      gq.push_back(b);
      void'(gq.pop_front());
      w[7-t] = b;
    end
    return ~w;
  endfunction

  function automatic void m_reset();
    rq.delete();
    lq.delete();
    for (int i = 0; i < W; i++) begin
      rq.push_back(1'b1);
      lq.push_back(1'b1);
    end
    m_locked = 0;
    m_run    = 0;
    m_cnt    = 0;
    m_out    = '0;
    m_valid  = 0;
  endfunction

  function automatic void m_step(input logic [7:0] w,
                                 input bit v, input bit clr);
    logic [7:0] r, mk;
    bit x, p, lk0;
    longint pc;
    pc  = 0;
    lk0 = m_locked;
    mk  = '0;
    if (v) begin
      r = ~w;
      for (int t = 0; t < 8; t++) begin
        x = r[7-t];
        if (lk0) begin
          p = rec(lq);
          lq.push_back(p);
          void'(lq.pop_front());
        end else begin
          p = rec(rq);
        end
        rq.push_back(x);
        void'(rq.pop_front());
        mk[7-t] = x ^ p;
        pc += longint'(x ^ p);
      end
      m_out = mk;
      if (!lk0) begin
        if (mk == 0) begin
          m_run++;
          if (m_run == 8) begin
            m_locked = 1;
            m_run    = 0;
            lq       = rq;
          end
        end else m_run = 0;
      end else begin
        if (mk != 0) begin
          m_run++;
          if (m_run == 4) begin
            m_locked = 0;
            m_run    = 0;
          end
        end else m_run = 0;
      end
    end
    m_valid = v;
    if (clr) m_cnt = (v && lk0) ? pc : 0;
    else if (v && lk0) m_cnt += pc;
  endfunction

  function automatic logic [31:0] e32();
    return (m_cnt > 64'hFFFFFFFF) ? 32'hFFFFFFFF : m_cnt[31:0];
  endfunction

  function automatic logic [3:0] e4();
    return (m_cnt > 15) ? 4'hF : m_cnt[3:0];
  endfunction

  task automatic step(input logic [7:0] w, input bit v,
                      input bit clr);
    @(negedge clk);
    rst           = 1'b0;
    data_in       = w;
    data_in_valid = v;
    err_clear     = clr;
    m_step(w, v, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    data_in       = 8'($urandom);
    data_in_valid = 1'b1;
    err_clear     = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    gen_reset();
    do_reset();
    n_vec++;
    if (a_lk !== 1'b0 || a_eov !== 1'b0 || a_eo !== 8'h00 ||
        a_cnt !== 32'd0 || a_sat !== 1'b0 ||
        b_cnt !== 4'd0 || b_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset: lk=%b v=%b eo=%h cnt=%0d/%0d sat=%b/%b want all 0",
               a_lk, a_eov, a_eo, a_cnt, b_cnt, a_sat, b_sat);
    end
  endtask

  task automatic test_lock();
    int first;
    first = -1;
    for (int i = 0; i < 1008; i++) begin
      step(gen_word(), 1'b1, 1'b0);
      if (a_lk === 1'b1 && first < 0) first = i;
      n_vec++;
      if (a_lk !== m_locked || a_eov !== 1'b1 ||
          a_eo !== m_out || a_cnt !== e32()) begin
        n_err++;
        $display("FAIL lock[%0d]: lk=%b v=%b eo=%h cnt=%0d want lk=%b v=1 eo=%h cnt=%0d",
                 i, a_lk, a_eov, a_eo, a_cnt, m_locked, m_out, e32());
      end
    end
    n_vec++;
    if (first !== 7 || a_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL lock_timing: first locked after word %0d cnt=%0d want word 7 cnt=0",
               first, a_cnt);
    end
  endtask

  task automatic test_single_flip();
    logic [31:0] c0;
    logic [7:0]  fm;
    for (int i = 0; i < int'($urandom_range(3, 20)); i++)
      step(gen_word(), 1'b1, 1'b0);
    c0 = a_cnt;
    step(gen_word() ^ 8'h08, 1'b1, 1'b0);
    n_vec++;
    if (a_eo !== 8'h08 || a_cnt !== c0 + 1 || a_lk !== 1'b1 ||
        a_eo !== m_out) begin
      n_err++;
      $display("FAIL flip3: eo=%h cnt=%0d lk=%b want eo=08 cnt=%0d lk=1",
               a_eo, a_cnt, a_lk, c0 + 1);
    end
    step(gen_word(), 1'b1, 1'b0);
    n_vec++;
    if (a_eo !== 8'h00 || a_cnt !== c0 + 1 || a_lk !== 1'b1) begin
      n_err++;
      $display("FAIL flip3_after: eo=%h cnt=%0d lk=%b want eo=00 cnt=%0d lk=1",
               a_eo, a_cnt, a_lk, c0 + 1);
    end
    fm = 8'(1 << $urandom_range(0, 7));
    step(gen_word() ^ fm, 1'b1, 1'b0);
    n_vec++;
    if (a_eo !== fm || a_cnt !== c0 + 2 || a_lk !== 1'b1) begin
      n_err++;
      $display("FAIL flip_rand: eo=%h cnt=%0d lk=%b want eo=%h cnt=%0d lk=1",
               a_eo, a_cnt, a_lk, fm, c0 + 2);
    end
  endtask

  task automatic test_burst();
    logic [7:0] g;
    bit relocked;
    for (int i = 0; i < 4; i++) begin
      g = gen_word();
      step(8'hA5, 1'b1, 1'b0);
      n_vec++;
      if (a_lk !== m_locked || a_eo !== m_out ||
          a_cnt !== e32() || b_cnt !== e4() || b_sat !== (m_cnt >= 15)) begin
        n_err++;
        $display("FAIL burst[%0d]: lk=%b eo=%h cnt=%0d/%0d want lk=%b eo=%h cnt=%0d/%0d",
                 i, a_lk, a_eo, a_cnt, b_cnt, m_locked, m_out, e32(), e4());
      end
    end
    n_vec++;
    if (a_lk !== 1'b0) begin
      n_err++;
      $display("FAIL burst_unlock: lk=%b want 0", a_lk);
    end
    relocked = 0;
    for (int i = 0; i < 40; i++) begin
      step(gen_word(), 1'b1, 1'b0);
      if (a_lk === 1'b1) relocked = 1;
      n_vec++;
      if (a_lk !== m_locked || a_eo !== m_out || a_cnt !== e32()) begin
        n_err++;
        $display("FAIL relock[%0d]: lk=%b eo=%h cnt=%0d want lk=%b eo=%h cnt=%0d",
                 i, a_lk, a_eo, a_cnt, m_locked, m_out, e32());
      end
    end
    n_vec++;
    if (!relocked) begin
      n_err++;
      $display("FAIL relock_seen: locked=%b want 1 within 40 words", a_lk);
    end
  endtask

  task automatic test_random_valid();
    bit v, clr, inj;
    int nv, lock_at;
    logic [7:0] w;
    gen_reset();
    do_reset();
    nv = 0;
    lock_at = -1;
    for (int i = 0; i < 400; i++) begin
      v   = 1'($urandom);
      inj = (lock_at >= 0) && ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 63) == 0);
      w   = v ? gen_word() : 8'($urandom);
      if (inj) w ^= 8'(1 << $urandom_range(0, 7));
      step(w, v, clr);
      if (v) nv++;
      if (a_lk === 1'b1 && lock_at < 0) lock_at = nv;
      n_vec++;
      if (a_eov !== m_valid || a_lk !== m_locked ||
          (m_valid && a_eo !== m_out) ||
          a_cnt !== e32() || b_cnt !== e4() ||
          b_sat !== (m_cnt >= 15)) begin
        n_err++;
        $display("FAIL rand[%0d]: v=%b lk=%b eo=%h cnt=%0d/%0d want v=%b lk=%b eo=%h cnt=%0d/%0d",
                 i, a_eov, a_lk, a_eo, a_cnt, b_cnt,
                 m_valid, m_locked, m_out, e32(), e4());
      end
    end
    n_vec++;
    if (lock_at !== 8) begin
      n_err++;
      $display("FAIL rand_lock_timing: locked after %0d valid words want 8",
               lock_at);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      step(gen_word() ^ 8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
      step(gen_word(), 1'b1, 1'b0);
      n_vec++;
      if (b_cnt !== e4() || b_sat !== (m_cnt >= 15) ||
          a_cnt !== e32() || a_lk !== m_locked) begin
        n_err++;
        $display("FAIL sat[%0d]: cnt4=%0d sat=%b cnt=%0d lk=%b want %0d %b %0d %b",
                 i, b_cnt, b_sat, a_cnt, a_lk,
                 e4(), m_cnt >= 15, e32(), m_locked);
      end
    end
    n_vec++;
    if (b_cnt !== 4'hF || b_sat !== 1'b1 || a_lk !== 1'b1) begin
      n_err++;
      $display("FAIL sat_hold: cnt4=%h sat=%b lk=%b want F 1 1",
               b_cnt, b_sat, a_lk);
    end
    step(gen_word(), 1'b1, 1'b1);
    n_vec++;
    if (b_cnt !== 4'h0 || b_sat !== 1'b0 || a_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL sat_clear: cnt4=%h sat=%b cnt=%0d want 0 0 0",
               b_cnt, b_sat, a_cnt);
    end
    step(gen_word() ^ 8'h81, 1'b1, 1'b1);
    n_vec++;
    if (b_cnt !== 4'h2 || a_cnt !== 32'd2 || b_sat !== 1'b0 ||
        a_eo !== 8'h81) begin
      n_err++;
      $display("FAIL clear_acc: cnt4=%h cnt=%0d sat=%b eo=%h want 2 2 0 81",
               b_cnt, a_cnt, b_sat, a_eo);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    n_vec++;
    if (a_lk !== 1'b0 || a_cnt !== 32'd0 || a_eov !== 1'b0 ||
        b_cnt !== 4'd0 || b_sat !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: lk=%b cnt=%0d/%0d v=%b sat=%b want 0",
               a_lk, a_cnt, b_cnt, a_eov, b_sat);
    end
    for (int i = 0; i < 30; i++) begin
      step(gen_word(), 1'b1, 1'b0);
      n_vec++;
      if (a_lk !== m_locked || a_eo !== m_out || a_cnt !== e32()) begin
        n_err++;
        $display("FAIL resume[%0d]: lk=%b eo=%h cnt=%0d want lk=%b eo=%h cnt=%0d",
                 i, a_lk, a_eo, a_cnt, m_locked, m_out, e32());
      end
    end
    n_vec++;
    if (a_lk !== 1'b1) begin
      n_err++;
      $display("FAIL resume_lock: lk=%b want 1", a_lk);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_flip();
    test_burst();
    test_random_valid();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
